// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: memory-op encoding, FSM states and exception causes.
package load_store_unit_pkg;

   typedef enum logic [3:0] {
      MEM_NOP,
      MEM_LB,
      MEM_LH,
      MEM_LW,
      MEM_LBU,
      MEM_LHU,
      MEM_SB,
      MEM_SH,
      MEM_SW
   } mem_op_t;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT_R,
      DONE
   } lsu_state_t;

   localparam logic [31:0] EXC_LD_MISALIGN = 32'd4;
   localparam logic [31:0] EXC_LD_FAULT    = 32'd5;
   localparam logic [31:0] EXC_ST_MISALIGN = 32'd6;
   localparam logic [31:0] EXC_ST_FAULT    = 32'd7;

   function automatic logic is_store(input mem_op_t op);
      return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for the load/store unit: byte enables, store-data replication,
// load lane extraction with sign/zero extension, and misalignment detection.
module lsu_align
   import load_store_unit_pkg::*;
(
   input  mem_op_t     op,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_lane,
   output logic [31:0] rdata_ext,
   output logic        misalign
);

   logic [31:0]        lane;
   logic signed [7:0]  lane_b;
   logic signed [15:0] lane_h;

   assign lane   = rdata >> {addr_lo, 3'b000};
   assign lane_b = lane[7:0];
   assign lane_h = lane[15:0];

   always_comb begin
      be         = 4'b0000;
      wdata_lane = 32'h0;
      rdata_ext  = 32'h0;
      misalign   = 1'b0;
      unique case (op)
         MEM_LB, MEM_LBU, MEM_SB: begin
            be         = 4'b0001 << addr_lo;
            wdata_lane = {4{wdata[7:0]}};
         end
         MEM_LH, MEM_LHU, MEM_SH: begin
            be         = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata_lane = {2{wdata[15:0]}};
            misalign   = addr_lo[0];
         end
         MEM_LW, MEM_SW: begin
            be         = 4'b1111;
            wdata_lane = wdata;
            misalign   = (addr_lo != 2'b00);
         end
         default: ;
      endcase
      // Signed casts carry the sign bit up for LB/LH.
      unique case (op)
         MEM_LB:  rdata_ext = 32'(lane_b);
         MEM_LBU: rdata_ext = {24'h0, lane[7:0]};
         MEM_LH:  rdata_ext = 32'(lane_h);
         MEM_LHU: rdata_ext = {16'h0, lane[15:0]};
         MEM_LW:  rdata_ext = lane;
         default: ;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: one data-bus transaction per load/store op, stalling the pipeline until done.
// Optional bus timeout (access fault) is enabled with the LSU_TIMEOUT_EN macro.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   input  mem_op_t     req_type_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        stall_o,
   output logic        done_o,
   output logic [31:0] rdata_o,
   output logic        exc_o,
   output logic [31:0] exc_cause_o,
   output logic [31:0] exc_tval_o,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [3:0]  bus_be_o,
   output logic [31:0] bus_wdata_o,
   input  logic        bus_gnt_i,
   input  logic        bus_rvalid_i,
   input  logic [31:0] bus_rdata_i
);

   lsu_state_t  state_q, state_d;
   mem_op_t     op_q;
   logic [31:0] addr_q, wdata_q, rdata_q, cause_q, tval_q;
   logic [3:0]  be_q;
   logic        exc_q;
   logic        accept, timeout;

   mem_op_t     align_op;
   logic [1:0]  align_addr;
   logic [3:0]  align_be;
   logic [31:0] align_wdata, align_rdata;
   logic        align_mis;

   assign accept     = (state_q == IDLE) && req_valid_i && (req_type_i != MEM_NOP);
   // In IDLE the aligner looks at the incoming op; afterwards at the latched one.
   assign align_op   = (state_q == IDLE) ? req_type_i   : op_q;
   assign align_addr = (state_q == IDLE) ? addr_i[1:0]  : addr_q[1:0];

   lsu_align u_align (
      .op         (align_op),
      .addr_lo    (align_addr),
      .wdata      (wdata_i),
      .rdata      (bus_rdata_i),
      .be         (align_be),
      .wdata_lane (align_wdata),
      .rdata_ext  (align_rdata),
      .misalign   (align_mis)
   );

`ifdef LSU_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if ((state_d != state_q) && ((state_d == REQ) || (state_d == WAIT_R))) begin
         cnt_q <= '0;
      end else if ((state_q == REQ) || (state_q == WAIT_R)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign timeout = ((state_q == REQ) || (state_q == WAIT_R)) &&
                    (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   wire unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:   if (accept) state_d = align_mis ? DONE : REQ;
         REQ: begin
            if (bus_gnt_i)    state_d = is_store(op_q) ? DONE : WAIT_R;
            else if (timeout) state_d = DONE;
         end
         WAIT_R: if (bus_rvalid_i || timeout) state_d = DONE;
         DONE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Result registers change only on the transition into DONE, so they hold between ops.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         op_q    <= MEM_NOP;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         be_q    <= 4'b0000;
         rdata_q <= 32'h0;
         exc_q   <= 1'b0;
         cause_q <= 32'h0;
         tval_q  <= 32'h0;
      end else if (accept) begin
         op_q    <= req_type_i;
         addr_q  <= addr_i;
         wdata_q <= align_wdata;
         be_q    <= align_be;
         if (align_mis) begin
            rdata_q <= 32'h0;
            exc_q   <= 1'b1;
            cause_q <= is_store(req_type_i) ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
            tval_q  <= addr_i;
         end
      end else if ((state_q == REQ) && bus_gnt_i && is_store(op_q)) begin
         rdata_q <= 32'h0;
         exc_q   <= 1'b0;
         cause_q <= 32'h0;
         tval_q  <= 32'h0;
      end else if ((state_q == WAIT_R) && bus_rvalid_i) begin
         rdata_q <= align_rdata;
         exc_q   <= 1'b0;
         cause_q <= 32'h0;
         tval_q  <= 32'h0;
      end else if (timeout && (state_d == DONE)) begin
         rdata_q <= 32'h0;
         exc_q   <= 1'b1;
         cause_q <= is_store(op_q) ? EXC_ST_FAULT : EXC_LD_FAULT;
         tval_q  <= addr_q;
      end
   end

   assign stall_o     = accept || (state_q == REQ) || (state_q == WAIT_R);
   assign done_o      = (state_q == DONE);
   assign rdata_o     = rdata_q;
   assign exc_o       = exc_q;
   assign exc_cause_o = cause_q;
   assign exc_tval_o  = tval_q;
   assign bus_req_o   = (state_q == REQ);
   assign bus_we_o    = is_store(op_q);
   assign bus_addr_o  = {addr_q[31:2], 2'b00};
   assign bus_be_o    = be_q;
   assign bus_wdata_o = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: vector table of single ops plus delayed-handshake and reset sequences.
module tb_load_store_unit;
   import load_store_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   mem_op_t     req_type = MEM_NOP;
   logic [31:0] addr = 32'h0, wdata = 32'h0;
   logic        stall_o, done_o, exc_o, bus_req_o, bus_we_o;
   logic [31:0] rdata_o, exc_cause_o, exc_tval_o, bus_addr_o, bus_wdata_o;
   logic [3:0]  bus_be_o;
   logic        bus_gnt = 1'b0, bus_rvalid = 1'b0;
   logic [31:0] bus_rdata = 32'h0;

   always #5 clk = ~clk;

   load_store_unit dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .req_valid_i  (req_valid),
      .req_type_i   (req_type),
      .addr_i       (addr),
      .wdata_i      (wdata),
      .stall_o      (stall_o),
      .done_o       (done_o),
      .rdata_o      (rdata_o),
      .exc_o        (exc_o),
      .exc_cause_o  (exc_cause_o),
      .exc_tval_o   (exc_tval_o),
      .bus_req_o    (bus_req_o),
      .bus_we_o     (bus_we_o),
      .bus_addr_o   (bus_addr_o),
      .bus_be_o     (bus_be_o),
      .bus_wdata_o  (bus_wdata_o),
      .bus_gnt_i    (bus_gnt),
      .bus_rvalid_i (bus_rvalid),
      .bus_rdata_i  (bus_rdata)
   );

   typedef struct {
      mem_op_t     op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] brdata;
      logic [3:0]  be;
      logic [31:0] bwdata;
      logic        we;
      logic [31:0] rdata;
      logic        exc;
      logic [31:0] cause;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        exc;
      logic [31:0] cause;
      logic [31:0] tval;
      int          lat;
   } exp_t;

   exp_t exp_q[$];
   vec_t vecs[13];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
      end
   endtask

   task automatic do_op(input vec_t v, input int gd, input int rd);
      exp_t e, got;
      int   cyc, gcnt, rcnt;
      bit   done, saw_req, granted;
      e.rdata = v.rdata;
      e.exc   = v.exc;
      e.cause = v.cause;
      e.tval  = v.addr;
      e.lat   = v.exc ? 1 : (v.we ? 2 + gd : 2 + gd + rd);
      @(negedge clk);
      req_valid = 1'b1; req_type = v.op; addr = v.addr; wdata = v.wdata;
      #1 chk("stall_accept", 32'(stall_o), 1);
      exp_q.push_back(e);
      @(negedge clk);
      req_valid = 1'b0; req_type = MEM_NOP; addr = 32'h0; wdata = 32'h0;
      cyc = 1; gcnt = 0; rcnt = 0; done = 0; saw_req = 0; granted = 0;
      while (!done && cyc < 40) begin
         bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
         if (done_o) begin
            done = 1;
            chk("stall_done", 32'(stall_o), 0);
            if (exp_q.size() == 0) begin
               chk("sb_empty", 1, 0);
            end else begin
               got = exp_q.pop_front();
               chk("latency", cyc, got.lat);
               chk("rdata", rdata_o, got.rdata);
               chk("exc", 32'(exc_o), 32'(got.exc));
               if (got.exc) begin
                  chk("cause", exc_cause_o, got.cause);
                  chk("tval", exc_tval_o, got.tval);
               end
            end
         end else begin
            chk("stall_busy", 32'(stall_o), 1);
            if (bus_req_o) begin
               saw_req = 1;
               chk("bus_addr", bus_addr_o, v.addr & 32'hFFFF_FFFC);
               chk("bus_be", 32'(bus_be_o), 32'(v.be));
               chk("bus_we", 32'(bus_we_o), 32'(v.we));
               chk("bus_wdata", bus_wdata_o, v.bwdata);
               if (gcnt == gd) begin
                  bus_gnt = 1'b1;
                  granted = 1;
               end
               gcnt++;
            end else if (granted) begin
               rcnt++;
               if (rcnt == rd) begin
                  bus_rvalid = 1'b1;
                  bus_rdata  = v.brdata;
               end
            end
            @(negedge clk);
            cyc++;
         end
      end
      if (!done) chk("done_timeout", 0, 1);
      chk("bus_req_seen", 32'(saw_req), 32'(!v.exc));
      @(negedge clk);
      chk("done_pulse", 32'(done_o), 0);
      chk("rdata_hold", rdata_o, v.rdata);
   endtask

   initial begin
      vecs[0]  = '{MEM_SW,  32'h100, 32'hDEADBEEF, 32'h0,        4'b1111, 32'hDEADBEEF, 1'b1, 32'h0,        1'b0, 32'd0};
      vecs[1]  = '{MEM_SB,  32'h103, 32'h000000A5, 32'h0,        4'b1000, 32'hA5A5A5A5, 1'b1, 32'h0,        1'b0, 32'd0};
      vecs[2]  = '{MEM_LB,  32'h101, 32'h0,        32'h123480FF, 4'b0010, 32'h0,        1'b0, 32'hFFFFFF80, 1'b0, 32'd0};
      vecs[3]  = '{MEM_LBU, 32'h101, 32'h0,        32'h123480FF, 4'b0010, 32'h0,        1'b0, 32'h00000080, 1'b0, 32'd0};
      vecs[4]  = '{MEM_LH,  32'h102, 32'h0,        32'h80011234, 4'b1100, 32'h0,        1'b0, 32'hFFFF8001, 1'b0, 32'd0};
      vecs[5]  = '{MEM_LHU, 32'h102, 32'h0,        32'h80011234, 4'b1100, 32'h0,        1'b0, 32'h00008001, 1'b0, 32'd0};
      vecs[6]  = '{MEM_LW,  32'h104, 32'h0,        32'hCAFEF00D, 4'b1111, 32'h0,        1'b0, 32'hCAFEF00D, 1'b0, 32'd0};
      vecs[7]  = '{MEM_SH,  32'h102, 32'h1234ABCD, 32'h0,        4'b1100, 32'hABCDABCD, 1'b1, 32'h0,        1'b0, 32'd0};
      vecs[8]  = '{MEM_LW,  32'h102, 32'h0,        32'h0,        4'b0000, 32'h0,        1'b0, 32'h0,        1'b1, 32'd4};
      vecs[9]  = '{MEM_SH,  32'h101, 32'h0,        32'h0,        4'b0000, 32'h0,        1'b1, 32'h0,        1'b1, 32'd6};
      vecs[10] = '{MEM_LH,  32'h103, 32'h0,        32'h0,        4'b0000, 32'h0,        1'b0, 32'h0,        1'b1, 32'd4};
      vecs[11] = '{MEM_SW,  32'h101, 32'h0,        32'h0,        4'b0000, 32'h0,        1'b1, 32'h0,        1'b1, 32'd6};
      vecs[12] = '{MEM_LB,  32'h103, 32'h0,        32'h7F000000, 4'b1000, 32'h0,        1'b0, 32'h0000007F, 1'b0, 32'd0};

      #2;
      chk("rst_ctrl", 32'({stall_o, done_o, exc_o, bus_req_o, bus_we_o, bus_be_o}), 0);
      chk("rst_rdata", rdata_o, 0);
      chk("rst_bus_addr", bus_addr_o, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // NOP with valid must not stall or start anything
      @(negedge clk);
      req_valid = 1'b1; req_type = MEM_NOP; addr = 32'h100;
      #1 chk("nop_stall", 32'(stall_o), 0);
      @(negedge clk);
      req_valid = 1'b0;
      chk("nop_idle", 32'({done_o, bus_req_o}), 0);

      for (int i = 0; i < 13; i++) do_op(vecs[i], 0, 1);

      // Slow bus: grant after 3 REQ cycles, read data 2 cycles after grant
      do_op('{MEM_LW, 32'h108, 32'h0, 32'h55AA33CC, 4'b1111, 32'h0, 1'b0, 32'h55AA33CC, 1'b0, 32'd0}, 3, 2);

      // Reset in WAIT_R, then a stale rvalid must be ignored
      @(negedge clk);
      req_valid = 1'b1; req_type = MEM_LW; addr = 32'h300;
      @(negedge clk);
      req_valid = 1'b0; req_type = MEM_NOP; addr = 32'h0;
      chk("rst_seq_req", 32'(bus_req_o), 1);
      bus_gnt = 1'b1;
      @(negedge clk);
      bus_gnt = 1'b0;
      chk("rst_seq_wait", 32'({bus_req_o, stall_o}), 32'b01);
      rst_n = 1'b0;
      #1;
      chk("midrst_ctrl", 32'({stall_o, done_o, exc_o, bus_req_o, bus_we_o, bus_be_o}), 0);
      chk("midrst_rdata", rdata_o, 0);
      chk("midrst_cause", exc_cause_o, 0);
      chk("midrst_tval", exc_tval_o, 0);
      chk("midrst_bus_addr", bus_addr_o, 0);
      chk("midrst_bus_wdata", bus_wdata_o, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      bus_rvalid = 1'b1; bus_rdata = 32'h12345678;
      @(negedge clk);
      bus_rvalid = 1'b0; bus_rdata = 32'h0;
      chk("stale_rvalid", 32'({done_o, stall_o}), 0);
      chk("stale_rdata", rdata_o, 0);

      do_op('{MEM_SW, 32'h200, 32'h0BADF00D, 32'h0, 4'b1111, 32'h0BADF00D, 1'b1, 32'h0, 1'b0, 32'd0}, 0, 1);

      chk("sb_drained", 32'(exp_q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got 0 expected 1");
      $fatal(1, "bench time limit");
   end

endmodule
